cpu_commit_monitor: RTL

Parametrised, synthesizable commit monitor attached beside the 5-stage RISC-V core. It samples the fetch PC/instruction and the MEM/WB writeback bus every cycle, keeps a shadow architectural register file, buffers writeback events in a trace FIFO, counts cycles and writebacks, and detects end-of-program (self-loop or ECALL) or timeout. It replaces hand-read `$monitor` debugging with a pass/fail-capable block usable both in simulation and on FPGA via the readback ports.

---
 rtl/cpu_commit_monitor_pkg.sv | 8 +
 rtl/cpu_commit_monitor_if.sv | 10 +
 rtl/cpu_commit_monitor_fifo.sv | 34 +++
 rtl/cpu_commit_monitor.sv | 60 ++++++
 4 files changed

// File: rtl/cpu_commit_monitor_pkg.sv
// cpu_mon_pkg: shared types and constants for the commit monitor
package cpu_mon_pkg;
    typedef enum logic [1:0] {RUN, HALT, TIMEOUT} mon_state_t;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
    function automatic int trace_w(int xlen, int ra_w);
        return xlen + ra_w;
    endfunction
endpackage

// File: rtl/cpu_commit_monitor_if.sv
// cpu_commit_monitor_if: fetch and MEM/WB writeback bus observed by the monitor
interface cpu_commit_monitor_if #(parameter int XLEN = 32, RA_W = 5);
    logic [XLEN-1:0] pc;
    logic [31:0] instr;
    logic wb_valid;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    modport master (output pc, instr, wb_valid, wb_rd, wb_data);
    modport slave (input pc, instr, wb_valid, wb_rd, wb_data);
endinterface

// File: rtl/cpu_commit_monitor_fifo.sv
// mon_trace_fifo: first-word-fall-through trace FIFO with sticky overflow
module mon_trace_fifo #(
    parameter int W = 37, DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input logic clk, rst,
    input logic wr_en,
    input logic [W-1:0] wr_data,
    input logic rd_en,
    output logic [W-1:0] rd_data,
    output logic empty, full, overflow
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_pop, do_push;
    assign empty = wptr == rptr;
    assign full = wptr == {~rptr[AW], rptr[AW-1:0]};
    assign do_pop = rd_en && !empty;
    // a pop in the same cycle frees the slot, so a push while full is accepted then
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];
    always_ff @(posedge clk)
        if (do_push) mem[wptr[AW-1:0]] <= wr_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            overflow <= 1'b0;
        end else begin
            wptr <= wptr + (AW+1)'(do_push);
            rptr <= rptr + (AW+1)'(do_pop);
            overflow <= overflow || (wr_en && !do_push);
        end
endmodule

// File: rtl/cpu_commit_monitor.sv
// cpu_commit_monitor: shadow regfile, writeback trace, counters and halt/timeout detection
module cpu_commit_monitor
    import cpu_mon_pkg::*;
#(
    parameter int XLEN = 32, REG_COUNT = 32, TRACE_DEPTH = 16, HALT_REPEAT = 4, TIMEOUT_CYCLES = 500,
    localparam int RA_W = $clog2(REG_COUNT)
) (
    input logic clk, rst,
    cpu_commit_monitor_if.slave core,
    input logic [RA_W-1:0] shadow_addr,
    output logic [XLEN-1:0] shadow_data,
    input logic trace_rd_en,
    output logic [trace_w(XLEN, RA_W)-1:0] trace_rd_data,
    output logic trace_empty, trace_full, trace_overflow,
    output logic [31:0] cycle_count, wb_count,
    output logic halted, timed_out
);
    localparam int SW = $clog2(HALT_REPEAT + 1);
    mon_state_t state;
    logic [XLEN-1:0] shadow [REG_COUNT];
    logic [XLEN-1:0] prev_pc;
    logic [SW-1:0] stable, stable_nxt;
    logic [31:0] cyc_nxt;
    logic run, halt_cond, to_cond, push;
    assign run = state == RUN;
    assign stable_nxt = core.pc == prev_pc ? stable + 1'b1 : '0;
    assign halt_cond = core.instr == ECALL_INSTR || stable_nxt >= SW'(HALT_REPEAT);
    assign cyc_nxt = &cycle_count ? cycle_count : cycle_count + 32'd1;
    assign to_cond = cyc_nxt >= 32'(TIMEOUT_CYCLES);
    assign push = run && core.wb_valid && core.wb_rd != '0;
    assign shadow_data = shadow[shadow_addr];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= RUN;
            halted <= 1'b0;
            timed_out <= 1'b0;
            prev_pc <= '0;
            stable <= '0;
            cycle_count <= '0;
            wb_count <= '0;
            for (int i = 0; i < REG_COUNT; i++) shadow[i] <= '0;
        end else if (run) begin
            // halt takes priority over a coincident timeout
            state <= halt_cond ? HALT : to_cond ? TIMEOUT : RUN;
            halted <= halt_cond;
            timed_out <= !halt_cond && to_cond;
            prev_pc <= core.pc;
            stable <= stable_nxt;
            cycle_count <= cyc_nxt;
            if (push) begin
                shadow[core.wb_rd] <= core.wb_data;
                wb_count <= &wb_count ? wb_count : wb_count + 32'd1;
            end
        end
    mon_trace_fifo #(.W(trace_w(XLEN, RA_W)), .DEPTH(TRACE_DEPTH)) u_trace (
        .clk(clk), .rst(rst), .wr_en(push), .wr_data({core.wb_rd, core.wb_data}),
        .rd_en(trace_rd_en), .rd_data(trace_rd_data),
        .empty(trace_empty), .full(trace_full), .overflow(trace_overflow)
    );
endmodule
